serial_addsub32: RTL and testbench

- Multi-cycle, digit-serial adder/subtractor. It computes the same {Cout,S} results as the combinational 32-bit ripple adder, and also performs subtraction.
- Operands enter through a valid/ready handshake. DIGIT bits are processed per clock, with the carry/borrow held in a flip-flop between digits.
- It is the area-lean counterpart in the ALU datapath and serves as a golden-result producer when cross-checking the ripple adder.

---
 rtl/serial_addsub32.sv | 96 +++++++++
 tb/tb_serial_addsub32.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub32.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock with the carry held
// in a flop, producing the same {Cout,S} as a full-width ripple adder, plus overflow V.
module serial_addsub32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] x_sh, y_sh, s_reg;
  logic             carry, v_reg;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  logic             msb_cin, last_digit, run_step, run_end, accept;

  assign accept     = in_valid && in_ready;
  assign run_end    = (cnt == CW'(NDIG));
  assign run_step   = (state == RUN) && !run_end;
  assign last_digit = (cnt == CW'(NDIG - 1));

  assign dsum = {1'b0, x_sh[DIGIT-1:0]} + {1'b0, y_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  // Carry into the top bit of the digit, recovered from that bit's sum
  assign msb_cin = x_sh[DIGIT-1] ^ y_sh[DIGIT-1] ^ dsum[DIGIT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (run_end) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Subtraction is folded into the operand load: Y and the carry-in are inverted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sh  <= '0;
      y_sh  <= '0;
      s_reg <= '0;
      carry <= 1'b0;
      v_reg <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      x_sh  <= X;
      y_sh  <= sub ? ~Y : Y;
      carry <= sub ? ~Cin : Cin;
      cnt   <= '0;
    end else if (run_step) begin
      x_sh  <= x_sh >> DIGIT;
      y_sh  <= y_sh >> DIGIT;
      s_reg <= (s_reg >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
      carry <= dsum[DIGIT];
      cnt   <= cnt + 1'b1;
      if (last_digit) v_reg <= msb_cin ^ dsum[DIGIT];
    end
  end

  assign S    = s_reg;
  assign Cout = carry;
  assign V    = v_reg;

endmodule

// File: tb/tb_serial_addsub32.sv
// Directed and random checks of serial_addsub32 with DIGIT=1 and DIGIT=8 instances
// driven in lockstep from the same operand stream.
module tb_serial_addsub32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] X = '0, Y = '0;
  logic        Cin = 1'b0, sub = 1'b0;

  logic        in_ready1, out_valid1, cout1, v1;
  logic [31:0] s1;
  logic        in_ready8, out_valid8, cout8, v8;
  logic [31:0] s8;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  serial_addsub32 #(.WIDTH(32), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .X(X), .Y(Y), .Cin(Cin), .sub(sub),
    .out_valid(out_valid1), .out_ready(out_ready),
    .S(s1), .Cout(cout1), .V(v1)
  );

  serial_addsub32 #(.WIDTH(32), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .X(X), .Y(Y), .Cin(Cin), .sub(sub),
    .out_valid(out_valid8), .out_ready(out_ready),
    .S(s8), .Cout(cout8), .V(v8)
  );

  // Issue one operation to both instances and check each result and latency
  task automatic do_op(input string name, input logic [31:0] xa, input logic [31:0] yb,
                       input logic ci, input logic sb, input logic [31:0] es,
                       input logic ec, input logic ev, input bit chk_lat);
    int cyc, lat1, lat8;
    X = xa; Y = yb; Cin = ci; sub = sb;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    X = $urandom; Y = $urandom; Cin = ~ci; sub = ~sb;
    cyc = 0; lat1 = -1; lat8 = -1;
    while ((lat1 < 0 || lat8 < 0) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid1 && lat1 < 0) lat1 = cyc;
      if (out_valid8 && lat8 < 0) lat8 = cyc;
    end
    if (chk_lat) begin
      tests_run++;
      if (lat1 !== 33) begin failures++; $display("[TB] FAIL %s lat_d1: got %0d want 33", name, lat1); end
      tests_run++;
      if (lat8 !== 5) begin failures++; $display("[TB] FAIL %s lat_d8: got %0d want 5", name, lat8); end
    end else begin
      tests_run++;
      if (lat1 < 0 || lat8 < 0) begin failures++; $display("[TB] FAIL %s timeout: lat1=%0d lat8=%0d want >=0", name, lat1, lat8); end
    end
    tests_run++;
    if ({s1, cout1, v1} !== {es, ec, ev}) begin
      failures++;
      $display("[TB] FAIL %s d1: S=%h C=%b V=%b want S=%h C=%b V=%b", name, s1, cout1, v1, es, ec, ev);
    end
    tests_run++;
    if ({s8, cout8, v8} !== {es, ec, ev}) begin
      failures++;
      $display("[TB] FAIL %s d8: S=%h C=%b V=%b want S=%h C=%b V=%b", name, s8, cout8, v8, es, ec, ev);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({in_ready1, out_valid1, s1, cout1, v1} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset: rdy=%b vld=%b S=%h C=%b V=%b want 1 0 0 0 0",
               in_ready1, out_valid1, s1, cout1, v1);
    end
  endtask

  task automatic test_add();
    do_op("add_1_0",     32'h1,        32'h0, 1'b0, 1'b0, 32'h1,        1'b0, 1'b0, 1'b1);
    do_op("add_wrap",    32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
    do_op("add_ovf",     32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
    do_op("add_cin",     32'h10,       32'h20, 1'b1, 1'b0, 32'h31,      1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    do_op("sub_5_3",     32'h5,        32'h3, 1'b0, 1'b1, 32'h2,        1'b1, 1'b0, 1'b1);
    do_op("sub_0_1",     32'h0,        32'h1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    do_op("sub_ovf",     32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
    do_op("sub_borrow",  32'h9,        32'h4, 1'b1, 1'b1, 32'h4,        1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int cyc;
    X = 32'h12345678; Y = 32'h11111111; Cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid1, in_ready1, s1, cout1, v1} !== {1'b1, 1'b0, 32'h23456789, 1'b0, 1'b0}) begin
        failures++;
        $display("[TB] FAIL hold[%0d]: vld=%b rdy=%b S=%h C=%b V=%b want 1 0 23456789 0 0",
                 i, out_valid1, in_ready1, s1, cout1, v1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if ({out_valid1, in_ready1, out_valid8, in_ready8} !== 4'b0101) begin
      failures++;
      $display("[TB] FAIL release: vld1=%b rdy1=%b vld8=%b rdy8=%b want 0 1 0 1",
               out_valid1, in_ready1, out_valid8, in_ready8);
    end
  endtask

  task automatic test_reset_midrun();
    X = 32'hFFFFFFFF; Y = 32'h0; Cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({in_ready1, out_valid1, s1, cout1, v1} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL midrun_rst d1: rdy=%b vld=%b S=%h C=%b V=%b want 1 0 0 0 0",
               in_ready1, out_valid1, s1, cout1, v1);
    end
    tests_run++;
    if ({in_ready8, out_valid8, s8} !== {1'b1, 1'b0, 32'h0}) begin
      failures++;
      $display("[TB] FAIL midrun_rst d8: rdy=%b vld=%b S=%h want 1 0 0", in_ready8, out_valid8, s8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("after_rst", 32'h2, 32'h2, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] xa, yb, ye, es;
    logic        ci, sb, ec, ev;
    logic [32:0] full;
    for (int n = 0; n < 1000; n++) begin
      xa = $urandom; yb = $urandom; ci = 1'($urandom); sb = 1'($urandom);
      if (n < 8) begin xa = 32'h80000000 >> n; yb = ~xa; end
      ye   = sb ? ~yb : yb;
      full = {1'b0, xa} + {1'b0, ye} + {32'h0, (sb ? ~ci : ci)};
      es   = full[31:0];
      ec   = full[32];
      ev   = (xa[31] == ye[31]) && (es[31] != xa[31]);
      do_op("random", xa, yb, ci, sb, es, ec, ev, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add();
    test_sub();
    test_backpressure();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
